// File: rtl/core_pkg.sv
// Shared fetch-path types: FSM encoding, response queue entry and
// the pair-address helper used by the fetcher.
package core_pkg;

  localparam int FETCH_QDEPTH = 2;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] data;
  } fetch_entry_t;

  // Address of the next aligned 64-bit pair; takes only the pair index
  // so callers cannot accidentally carry word-offset bits forward.
  function automatic logic [31:0] next_pair_pc(input logic [28:0] pair_idx);
    return {pair_idx + 29'd1, 3'b000};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO holding returned fetch pairs until the
// instruction buffer can accept them. Clear has priority over push/pop.
module fetch_queue
  import core_pkg::*;
#(
  parameter int DEPTH = FETCH_QDEPTH,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  input  logic          clear,
  output logic [CW-1:0] count,
  output fetch_entry_t  head
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Pointer, occupancy and storage update; the caller guarantees no push when full.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Queue state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instruction_fetcher.sv
// Front-end fetch unit: issues aligned 64-bit fetches, squashes responses
// that were in flight at a redirect, and hands up to two instructions per
// cycle to the instruction buffer.
module instruction_fetcher
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = FETCH_QDEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic [31:0] instructionA,
  output logic [31:0] instructionB,
  output logic [31:0] addressA,
  output logic [31:0] addressB,
  output logic        instructionA_valid,
  output logic        instructionB_valid
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW:0] QDEPTH_LIM = (CW + 1)'(QDEPTH);

  fetch_state_t  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] squash_cnt_q, squash_cnt_d;

  logic [31:0]   instr_a_q, instr_a_d;
  logic [31:0]   instr_b_q, instr_b_d;
  logic [31:0]   addr_a_q, addr_a_d;
  logic [31:0]   addr_b_q, addr_b_d;
  logic          valid_a_q, valid_a_d;
  logic          valid_b_q, valid_b_d;

  logic [CW:0]   occupancy;
  logic          granted;
  logic          rsp_live;
  logic          bypass;
  logic          q_push;
  logic          q_pop;
  logic [CW-1:0] q_count;
  fetch_entry_t  q_head;
  fetch_entry_t  push_entry;
  fetch_entry_t  sel;
  logic          load_out;
  logic [31:0]   redirect_word;
  logic          unused_bits;

  // Only word-aligned fetch and redirect addresses matter; low bits are dropped.
  assign unused_bits   = ^{redirect_pc[1:0], fetch_pc_q[2:0]};
  assign redirect_word = {redirect_pc[31:2], 2'b00};

  fetch_queue #(
    .DEPTH(QDEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (q_push),
    .push_entry (push_entry),
    .pop        (q_pop),
    .clear      (flush),
    .count      (q_count),
    .head       (q_head)
  );

  // Request issue and response routing. A flush withdraws any pending request
  // and kills a response landing on the same edge.
  always_comb begin
    occupancy  = {1'b0, inflight_q} + {1'b0, q_count};
    mem_req    = (state_q == S_RUN) && !flush && (occupancy < QDEPTH_LIM);
    mem_addr   = {fetch_pc_q[31:3], 3'b000};
    granted    = mem_req && mem_gnt;
    rsp_live   = mem_rvalid && (squash_cnt_q == '0) && !flush;
    bypass     = rsp_live && (q_count == '0) && !stall;
    q_push     = rsp_live && !bypass;
    q_pop      = !flush && !stall && (q_count != '0);
    push_entry = '{pc: resp_pc_q, data: mem_rdata};
  end

  // Counters and PCs. resp_pc tracks the tag of the next live response: live
  // responses return in request order starting at the last redirect target,
  // so it advances exactly like fetch_pc does on grant.
  always_comb begin
    inflight_d   = inflight_q;
    squash_cnt_d = squash_cnt_q;
    fetch_pc_d   = fetch_pc_q;
    resp_pc_d    = resp_pc_q;
    case ({granted, mem_rvalid})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
    if (flush) begin
      squash_cnt_d = inflight_q - (mem_rvalid ? CW'(1) : CW'(0));
      fetch_pc_d   = redirect_word;
      resp_pc_d    = redirect_word;
    end else begin
      if (mem_rvalid && (squash_cnt_q != '0)) begin
        squash_cnt_d = squash_cnt_q - CW'(1);
      end
      if (granted) begin
        fetch_pc_d = next_pair_pc(fetch_pc_q[31:3]);
      end
      if (rsp_live) begin
        resp_pc_d = next_pair_pc(resp_pc_q[31:3]);
      end
    end
  end

  // FSM next state: drain until every stale response is gone.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   if (flush && (squash_cnt_d != '0)) state_d = S_DRAIN;
      S_DRAIN: if (squash_cnt_d == '0) state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
  end

  // Output pair selection: queue head first, otherwise bypass the fresh response.
  always_comb begin
    instr_a_d = instr_a_q;
    instr_b_d = instr_b_q;
    addr_a_d  = addr_a_q;
    addr_b_d  = addr_b_q;
    valid_a_d = 1'b0;
    valid_b_d = 1'b0;
    sel       = q_pop ? q_head : push_entry;
    load_out  = q_pop || bypass;
    if (load_out) begin
      addr_a_d  = sel.pc;
      valid_a_d = 1'b1;
      if (!sel.pc[2]) begin
        instr_a_d = sel.data[31:0];
        instr_b_d = sel.data[63:32];
        addr_b_d  = sel.pc + 32'd4;
        valid_b_d = 1'b1;
      end else begin
        instr_a_d = sel.data[63:32];
      end
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_BOOT;
      fetch_pc_q   <= RESET_PC;
      resp_pc_q    <= RESET_PC;
      inflight_q   <= '0;
      squash_cnt_q <= '0;
      instr_a_q    <= '0;
      instr_b_q    <= '0;
      addr_a_q     <= '0;
      addr_b_q     <= '0;
      valid_a_q    <= 1'b0;
      valid_b_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      resp_pc_q    <= resp_pc_d;
      inflight_q   <= inflight_d;
      squash_cnt_q <= squash_cnt_d;
      instr_a_q    <= instr_a_d;
      instr_b_q    <= instr_b_d;
      addr_a_q     <= addr_a_d;
      addr_b_q     <= addr_b_d;
      valid_a_q    <= valid_a_d;
      valid_b_q    <= valid_b_d;
    end
  end

  assign instructionA       = instr_a_q;
  assign instructionB       = instr_b_q;
  assign addressA           = addr_a_q;
  assign addressB           = addr_b_q;
  assign instructionA_valid = valid_a_q;
  assign instructionB_valid = valid_b_q;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed bench for instruction_fetcher: a memory model with selectable
// latency, a scoreboard of expected pairs, and a monitor that checks every
// pair the fetcher presents.
module tb_instruction_fetcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic [31:0] instructionA;
  logic [31:0] instructionB;
  logic [31:0] addressA;
  logic [31:0] addressB;
  logic        instructionA_valid;
  logic        instructionB_valid;

  typedef struct {
    logic [31:0] addr_a;
    logic        has_b;
  } exp_pair_t;

  exp_pair_t   exp_q[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          checks = 0;
  int          errors = 0;
  int          lat = 1;
  int          cyc = 0;
  bit          done = 1'b0;

  instruction_fetcher #(
    .RESET_PC (32'h0000_0100),
    .QDEPTH   (2)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .stall              (stall),
    .flush              (flush),
    .redirect_pc        (redirect_pc),
    .mem_req            (mem_req),
    .mem_addr           (mem_addr),
    .mem_gnt            (mem_gnt),
    .mem_rvalid         (mem_rvalid),
    .mem_rdata          (mem_rdata),
    .instructionA       (instructionA),
    .instructionB       (instructionB),
    .addressA           (addressA),
    .addressB           (addressB),
    .instructionA_valid (instructionA_valid),
    .instructionB_valid (instructionB_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_0F69;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expectPair(input logic [31:0] a, input logic b);
    exp_pair_t e;
    e.addr_a = a;
    e.has_b  = b;
    exp_q.push_back(e);
  endtask

  // Drive one cycle's inputs just after the rising edge, then wait for the
  // falling edge where outputs are sampled.
  task automatic applyStimulus(input logic f, input logic [31:0] rpc, input logic s, input logic g);
    @(posedge clk);
    #1;
    flush       = f;
    redirect_pc = rpc;
    stall       = s;
    mem_gnt     = g;
    @(negedge clk);
  endtask

  task automatic checkReq(input string name, input logic r, input logic [31:0] a);
    checkOutput(name, 128'({mem_req, mem_addr}), 128'({r, a}));
  endtask

  // In-order memory: grants seen in a cycle return lat cycles later.
  initial begin
    logic        g;
    logic [31:0] a;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      g = rst_n && mem_req && mem_gnt;
      a = mem_addr;
      @(posedge clk);
      cyc++;
      if (g) begin
        pend_addr.push_back(a);
        pend_due.push_back(cyc + lat - 1);
      end
      #1;
      if (!rst_n) begin
        pend_addr.delete();
        pend_due.delete();
      end
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = {mem_word(pend_addr[0] + 32'd4), mem_word(pend_addr[0])};
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        mem_rvalid = 1'b0;
      end
    end
  end

  // Monitor: every presented pair must match the scoreboard head.
  initial begin
    exp_pair_t e;
    forever begin
      @(negedge clk);
      if (rst_n && !done) begin
        if (instructionB_valid) begin
          checkOutput("b_implies_a", 128'(instructionA_valid), 128'(1'b1));
        end
        if (instructionA_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_pair: got addressA %0h expected none", addressA);
          end else begin
            e = exp_q.pop_front();
            checkOutput("pair_a", 128'({addressA, instructionA, instructionB_valid}),
                        128'({e.addr_a, mem_word(e.addr_a), e.has_b}));
            if (e.has_b) begin
              checkOutput("pair_b", 128'({addressB, instructionB}),
                          128'({e.addr_a + 32'd4, mem_word(e.addr_a + 32'd4)}));
            end
          end
        end
      end
    end
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    if (!done) begin
      errors++;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  // Directed sequence.
  initial begin
    rst_n       = 1'b0;
    stall       = 1'b0;
    flush       = 1'b0;
    redirect_pc = '0;
    mem_gnt     = 1'b1;
    repeat (2) @(negedge clk);
    $display("[TB] reset checks");
    checkReq("reset_req", 1'b0, 32'h0000_0100);
    checkOutput("reset_valids", 128'({instructionA_valid, instructionB_valid}), 128'(2'b00));
    checkOutput("reset_outputs", 128'({instructionA, instructionB, addressA, addressB}), 128'(0));

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkReq("boot_no_req", 1'b0, 32'h0000_0100);

    $display("[TB] sequential fetch from 0x100");
    expectPair(32'h0000_0100, 1'b1);
    expectPair(32'h0000_0108, 1'b1);
    expectPair(32'h0000_0110, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkReq("req_0x100", 1'b1, 32'h0000_0100);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkReq("req_0x108", 1'b1, 32'h0000_0108);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkReq("req_0x110", 1'b1, 32'h0000_0110);

    $display("[TB] grant held low, then flush to 0x204");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      checkReq("gnt_low_hold", 1'b1, 32'h0000_0118);
    end
    expectPair(32'h0000_0204, 1'b0);
    expectPair(32'h0000_0208, 1'b1);
    applyStimulus(1'b1, 32'h0000_0204, 1'b0, 1'b0);
    checkOutput("flush_withdraw", 128'(mem_req), 128'(1'b0));
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkReq("redirect_req", 1'b1, 32'h0000_0200);
    checkOutput("flush_valids_low", 128'({instructionA_valid, instructionB_valid}), 128'(2'b00));
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkReq("req_0x208", 1'b1, 32'h0000_0208);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkReq("req_0x210_wait", 1'b1, 32'h0000_0210);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

    $display("[TB] stall with full queue");
    expectPair(32'h0000_0210, 1'b1);
    expectPair(32'h0000_0218, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkReq("stall_req_0x210", 1'b1, 32'h0000_0210);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkReq("stall_req_0x218", 1'b1, 32'h0000_0218);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput("stall_full_no_req", 128'(mem_req), 128'(1'b0));
      checkOutput("stall_valids_low", 128'({instructionA_valid, instructionB_valid}), 128'(2'b00));
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("unstall_valids_low", 128'({instructionA_valid, instructionB_valid}), 128'(2'b00));
    checkOutput("unstall_no_req", 128'(mem_req), 128'(1'b0));
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkReq("req_after_pop", 1'b1, 32'h0000_0220);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

    $display("[TB] latency 3, flush with two in flight");
    lat = 3;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkReq("lat3_req_0x220", 1'b1, 32'h0000_0220);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkReq("lat3_req_0x228", 1'b1, 32'h0000_0228);
    applyStimulus(1'b1, 32'h0000_0300, 1'b0, 1'b0);
    checkOutput("lat3_flush_no_req", 128'(mem_req), 128'(1'b0));
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("drain_no_req_1", 128'(mem_req), 128'(1'b0));
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("drain_no_req_2", 128'(mem_req), 128'(1'b0));
    expectPair(32'h0000_0300, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkReq("drain_done_req", 1'b1, 32'h0000_0300);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkReq("req_0x308", 1'b1, 32'h0000_0308);
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

    $display("[TB] address wrap");
    lat = 1;
    expectPair(32'hFFFF_FFF8, 1'b1);
    expectPair(32'h0000_0000, 1'b1);
    applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkReq("wrap_req_top", 1'b1, 32'hFFFF_FFF8);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkReq("wrap_req_zero", 1'b1, 32'h0000_0000);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkReq("wrap_req_0x8", 1'b1, 32'h0000_0008);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

    $display("[TB] flush together with stall");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkReq("fs_req_0x8", 1'b1, 32'h0000_0008);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkReq("fs_req_0x10", 1'b1, 32'h0000_0010);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("fs_full_no_req", 128'(mem_req), 128'(1'b0));
    expectPair(32'h0000_0400, 1'b1);
    applyStimulus(1'b1, 32'h0000_0400, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkReq("fs_redirect_req", 1'b1, 32'h0000_0400);
    checkOutput("fs_valids_low", 128'({instructionA_valid, instructionB_valid}), 128'(2'b00));
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkReq("fs_req_0x408", 1'b1, 32'h0000_0408);
    repeat (6) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

    checkOutput("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
